// File: rtl/comm_cmd_sched.sv
// Round-robin owner of the communications command engine: grants one requester,
// drives the command/start handshake under a watchdog, then enforces a guard gap.
module comm_cmd_sched #(
  parameter int NREQ       = 2,
  parameter int CMD_W      = 3,
  parameter int TIMEOUT    = 50000000,
  parameter int GAP_CYCLES = 2000,
  parameter int TMR_W      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic [CMD_W-1:0]      command_1,
  output logic                  start,
  input  logic                  ready_command,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAITCOM, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]    owner_q, owner_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [NREQ-1:0]    err_q, err_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic [CMD_W-1:0]   cmd_slice [NREQ];
  logic               win_any;
  logic [PTR_W-1:0]   win_idx;
  logic [NREQ-1:0]    win_oh;
  logic [CMD_W-1:0]   win_cmd;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign cmd_slice[gi] = req_cmd[gi*CMD_W +: CMD_W];
  end

  // Two descending passes: the second (indices above ptr) overrides the wrapped
  // group, so the lowest index after ptr wins, else the lowest at/below ptr.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    win_cmd = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(ptr_q))) begin
        win_any = 1'b1;
        win_idx = PTR_W'(i);
        win_oh  = NREQ'(1) << i;
        win_cmd = cmd_slice[i];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr_q))) begin
        win_any = 1'b1;
        win_idx = PTR_W'(i);
        win_oh  = NREQ'(1) << i;
        win_cmd = cmd_slice[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    start_d = start_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        if (win_any && ready_command) begin
          owner_d = win_oh;
          ptr_d   = win_idx;
          cmd_d   = win_cmd;
          gnt_d   = win_oh;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        start_d = 1'b1;
        // Engine acceptance is checked before the watchdog so it wins a tie.
        if (!ready_command) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAITCOM;
        end else if (cnt_q == TO_LAST) begin
          start_d = 1'b0;
          err_d   = owner_q;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      S_WAITCOM: begin
        start_d = 1'b0;
        if (ready_command) begin
          done_d  = owner_q;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = owner_q;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        start_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        owner_d = '0;
        cmd_d   = '0;
        start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
      owner_q <= '0;
      cmd_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign command_1 = cmd_q;
  assign start     = start_q;
  assign busy      = busy_q;

endmodule
